booth_mult_arbiter: RTL and testbench

- Shares one instance of the combinational 4x4 signed Booth multiplier `booth_m` (ports x, y, p) between two requesters.
- Round-robin arbitration; valid/ready handshakes on both the request and response side.
- Operands are registered before the multiplier and the product is registered after it, so the datapath sees stable inputs for a full cycle.
- Sits between the operand sources and the shared `booth_m` instance; also keeps a completed-operation count for debug.

---
 rtl/booth_mult_arbiter.sv | 138 +++++++++++++
 tb/tb_booth_mult_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_arbiter.sv
// Two-requester round-robin front end for one shared 4x4 signed Booth multiplier.
// Operands and product are registered around the multiplier; one op in flight.

module booth_m (
  input  logic signed [3:0] x,
  input  logic signed [3:0] y,
  output logic signed [7:0] p
);

  logic signed [7:0] w_xe;
  logic [4:0]        w_yb;

  assign w_xe = {{4{x[3]}}, x};
  assign w_yb = {y, 1'b0};

  // Radix-2 Booth recoding: (y[i], y[i-1]) = 01 adds, 10 subtracts
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      case ({w_yb[i+1], w_yb[i]})
        2'b01:   p = p + (w_xe <<< i);
        2'b10:   p = p - (w_xe <<< i);
        default: p = p;
      endcase
    end
  end

endmodule

module booth_mult_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [3:0]       req0_x,
  input  logic [3:0]       req0_y,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [3:0]       req1_x,
  input  logic [3:0]       req1_y,
  output logic             req1_ready,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [7:0]       rsp_p,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_owner;
  logic             r_last;
  logic [3:0]       r_x;
  logic [3:0]       r_y;
  logic [7:0]       r_p;
  logic [CNT_W-1:0] r_cnt;

  logic             w_idle;
  logic             w_g0;
  logic             w_g1;
  logic             w_acc;
  logic             w_done;
  logic [7:0]       w_p;

  booth_m u_mul (
    .x (r_x),
    .y (r_y),
    .p (w_p)
  );

  // r_last == 1 means requester 1 was granted last, so req0 wins a tie
  assign w_idle = (r_state == S_IDLE);
  assign w_g0   = req0_valid && (!req1_valid || r_last);
  assign w_g1   = req1_valid && (!req0_valid || !r_last);
  assign w_acc  = w_idle && (w_g0 || w_g1);
  assign w_done = (r_state == S_RESP)
               && (r_owner ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_acc) w_next = S_MUL;
      S_MUL:   w_next = S_RESP;
      S_RESP:  if (w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_x     <= '0;
      r_y     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_x     <= w_g1 ? req1_x : req0_x;
        r_y     <= w_g1 ? req1_y : req0_y;
        r_owner <= w_g1;
        r_last  <= w_g1;
      end
      if (r_state == S_MUL) begin
        r_p <= w_p;
      end
      if (w_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign req0_ready = w_idle && w_g0;
  assign req1_ready = w_idle && w_g1;
  assign rsp0_valid = (r_state == S_RESP) && !r_owner;
  assign rsp1_valid = (r_state == S_RESP) && r_owner;
  assign rsp_p      = r_p;
  assign busy       = !w_idle;
  assign done_cnt   = r_cnt;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: per-requester operand queues feed the DUT,
// accepted ops go to a scoreboard checked on each response handshake.

module tb_booth_mult_arbiter;

  localparam int CW = 2;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } op_t;

  typedef struct packed {
    logic       own;
    logic [7:0] p;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0;
  logic [3:0]    req0_x = '0;
  logic [3:0]    req0_y = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [3:0]    req1_x = '0;
  logic [3:0]    req1_y = '0;
  logic          req1_ready;
  logic          rsp0_valid;
  logic          rsp0_ready = 1'b1;
  logic          rsp1_valid;
  logic          rsp1_ready = 1'b1;
  logic [7:0]    rsp_p;
  logic          busy;
  logic [CW-1:0] done_cnt;

  int            ncmp = 0;
  int            nerr = 0;
  op_t           q0[$];
  op_t           q1[$];
  exp_t          sb[$];
  logic [CW-1:0] mcnt = '0;
  bit            a0 = 1'b0;
  bit            a1 = 1'b0;

  booth_mult_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_p      (rsp_p),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] smul(input logic [3:0] a,
                                      input logic [3:0] b);
    logic signed [7:0] sa;
    logic signed [7:0] sb2;
    sa  = {{4{a[3]}}, a};
    sb2 = {{4{b[3]}}, b};
    return 8'(sa * sb2);
  endfunction

  // Operand drivers: hold head of queue valid until accepted
  always @(negedge clk) begin
    a0 = rst_n && req0_valid && req0_ready;
    a1 = rst_n && req1_valid && req1_ready;
  end

  always @(posedge clk) begin
    #1;
    if (a0) begin
      sb.push_back({1'b0, smul(q0[0].x, q0[0].y)});
      void'(q0.pop_front());
    end
    if (a1) begin
      sb.push_back({1'b1, smul(q1[0].x, q1[0].y)});
      void'(q1.pop_front());
    end
    a0 = 1'b0;
    a1 = 1'b0;
    if (q0.size() > 0) begin
      req0_valid = 1'b1;
      req0_x     = q0[0].x;
      req0_y     = q0[0].y;
    end else begin
      req0_valid = 1'b0;
      req0_x     = 4'($urandom);
      req0_y     = 4'($urandom);
    end
    if (q1.size() > 0) begin
      req1_valid = 1'b1;
      req1_x     = q1[0].x;
      req1_y     = q1[0].y;
    end else begin
      req1_valid = 1'b0;
      req1_x     = 4'($urandom);
      req1_y     = 4'($urandom);
    end
  end

  // Response monitor and invariants
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      mcnt = '0;
    end else begin
      ncmp++;
      if ({req0_ready && req1_ready, rsp0_valid && rsp1_valid,
           busy && (req0_ready || req1_ready)} !== 3'b000) begin
        nerr++;
        $display("FAIL excl: got r%b%b v%b%b b%b required exclusive",
                 req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy);
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        ncmp++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL rsp_unexp: got v%b%b p=%h required none",
                   rsp1_valid, rsp0_valid, rsp_p);
        end else begin
          e = sb.pop_front();
          mcnt = mcnt + 1'b1;
          if ({rsp1_valid, rsp0_valid, rsp_p} !== {e.own, !e.own, e.p}) begin
            nerr++;
            $display("FAIL rsp: got v1=%b v0=%b p=%h required v1=%b p=%h",
                     rsp1_valid, rsp0_valid, rsp_p, e.own, e.p);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0
          && !busy && !req0_valid && !req1_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    ncmp++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
      nerr++;
      $display("FAIL reset_ctl: got %b required 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
    end
    ncmp++;
    if ({rsp_p, done_cnt} !== '0) begin
      nerr++;
      $display("FAIL reset_dat: got p=%h cnt=%0d required 0", rsp_p, done_cnt);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    q0.push_back({4'h8, 4'hC});
    @(negedge clk);
    ncmp++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      nerr++;
      $display("FAIL single_acc: got %b required 100",
               {req0_ready, req1_ready, busy});
    end
    @(negedge clk);
    ncmp++;
    if ({busy, rsp0_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL single_mul: got %b required 10", {busy, rsp0_valid});
    end
    @(negedge clk);
    ncmp++;
    if ({rsp0_valid, rsp1_valid, rsp_p} !== {2'b10, 8'h20}) begin
      nerr++;
      $display("FAIL single_rsp: got v%b%b p=%h required v10 p=20",
               rsp0_valid, rsp1_valid, rsp_p);
    end
    @(negedge clk);
    ncmp++;
    if ({busy, done_cnt} !== {1'b0, 2'd1}) begin
      nerr++;
      $display("FAIL single_cnt: got b=%b cnt=%0d required b=0 cnt=1",
               busy, done_cnt);
    end
  endtask

  task automatic test_contention();
    bit ok;
    bit seen;
    do_reset();
    @(negedge clk);
    q0.push_back({4'd3, 4'd5});
    q1.push_back({4'hE, 4'd7});
    @(negedge clk);
    ncmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++;
      $display("FAIL cont_first: got %b required 10", {req0_ready, req1_ready});
    end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = req1_ready;
    end
    ncmp++;
    if (!seen) begin
      nerr++;
      $display("FAIL cont_second: got no req1_ready required grant");
    end
    wait_idle(20, ok);
    ncmp++;
    if ({ok, done_cnt} !== {1'b1, 2'd2}) begin
      nerr++;
      $display("FAIL cont_cnt: got ok=%b cnt=%0d required ok=1 cnt=2",
               ok, done_cnt);
    end
    q0.push_back({4'd1, 4'hF});
    q1.push_back({4'd2, 4'd2});
    @(negedge clk);
    ncmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++;
      $display("FAIL cont_alt: got %b required 10", {req0_ready, req1_ready});
    end
    wait_idle(20, ok);
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL cont_idle: got timeout required idle");
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    @(posedge clk);
    #2 rsp1_ready = 1'b0;
    @(negedge clk);
    q1.push_back({4'h8, 4'h8});
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = rsp1_valid;
    end
    ncmp++;
    if (!seen) begin
      nerr++;
      $display("FAIL bp_valid: got no rsp1_valid required valid");
    end
    q0.push_back({4'd1, 4'd2});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ncmp++;
      if ({rsp1_valid, busy, req0_ready, req0_valid, rsp_p}
          !== {4'b1101, 8'h40}) begin
        nerr++;
        $display("FAIL bp_hold: got %b p=%h required 1101 p=40",
                 {rsp1_valid, busy, req0_ready, req0_valid}, rsp_p);
      end
    end
    @(posedge clk);
    #2 rsp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ncmp++;
    if ({req0_ready, busy} !== 2'b10) begin
      nerr++;
      $display("FAIL bp_regrant: got %b required 10", {req0_ready, busy});
    end
    wait_idle(20, ok);
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL bp_idle: got timeout required idle");
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    @(negedge clk);
    q0.push_back({4'd7, 4'd7});
    @(negedge clk);
    ncmp++;
    if (req0_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_acc: got %b required 1", req0_ready);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ncmp++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, rsp_p,
         done_cnt} !== '0) begin
      nerr++;
      $display("FAIL rst_mid: got v0=%b b=%b p=%h cnt=%0d required 0",
               rsp0_valid, busy, rsp_p, done_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    ncmp++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      nerr++;
      $display("FAIL rst_after: got %b required 00", {rsp0_valid, busy});
    end
    q0.push_back({4'd1, 4'd1});
    q1.push_back({4'd2, 4'd3});
    @(negedge clk);
    ncmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      nerr++;
      $display("FAIL rst_grant: got %b required 10", {req0_ready, req1_ready});
    end
    wait_idle(20, ok);
    ncmp++;
    if (!ok) begin
      nerr++;
      $display("FAIL rst_idle: got timeout required idle");
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i % 2 == 0) q0.push_back({4'd1, 4'd1});
      else q1.push_back({4'd1, 4'd1});
      wait_idle(20, ok);
      ncmp++;
      if ({ok, done_cnt} !== {1'b1, exp_c[i]}) begin
        nerr++;
        $display("FAIL wrap_%0d: got ok=%b cnt=%0d required ok=1 cnt=%0d",
                 i, ok, done_cnt, exp_c[i]);
      end
    end
  endtask

  task automatic test_sweep();
    bit ok;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      if (i % 2 == 0) q0.push_back(8'(i));
      else q1.push_back(8'(i));
    end
    wait_idle(3000, ok);
    ncmp++;
    if ({ok, done_cnt} !== {1'b1, mcnt}) begin
      nerr++;
      $display("FAIL sweep: got ok=%b cnt=%0d required ok=1 cnt=%0d",
               ok, done_cnt, mcnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reset_midop();
    test_wrap();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
